// File: rtl/load_bias_pp_if.sv
// AXI read-channel bundle between the bias loader (master) and the DDR read mux (slave).
interface load_bias_pp_if #(
    parameter int unsigned C_M_AXI_LEN_WIDTH  = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 128
);
    logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen;
    logic                          I_maxi_arready;
    logic                          O_maxi_arvalid;
    logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr;
    logic                          O_stable_rready;
    logic                          I_maxi_rvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata;

    modport master (
        output O_maxi_arlen,
        output O_maxi_arvalid,
        output O_maxi_araddr,
        output O_stable_rready,
        input  I_maxi_arready,
        input  I_maxi_rvalid,
        input  I_maxi_rdata
    );

    modport slave (
        input  O_maxi_arlen,
        input  O_maxi_arvalid,
        input  O_maxi_araddr,
        input  O_stable_rready,
        output I_maxi_arready,
        output I_maxi_rvalid,
        output I_maxi_rdata
    );
endinterface

// File: rtl/load_bias_pp.sv
// Ping-pong bias loader: fetches beats over AXI read, packs them into wide words and
// writes them into one bank of a two-bank RAM while the other bank is read by compute.
module load_bias_pp #(
    parameter int unsigned C_M_AXI_LEN_WIDTH  = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
    parameter int unsigned C_LBIAS_WIDTH      = 512,
    parameter int unsigned C_RAM_ADDR_WIDTH   = 10,
    parameter int unsigned C_MAX_BURST        = 16
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    output logic                          O_busy,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
    input  logic                          I_wbank,
    input  logic                          I_rbank,
    input  logic [C_RAM_ADDR_WIDTH-$clog2(C_LBIAS_WIDTH/C_M_AXI_DATA_WIDTH)-1:0] I_braddr,
    output logic [C_LBIAS_WIDTH-1:0]      O_brdata,
    load_bias_pp_if.master                m_axi
);

    localparam int unsigned C_PACK      = C_LBIAS_WIDTH / C_M_AXI_DATA_WIDTH;
    localparam int unsigned C_PACK_LOG2 = $clog2(C_PACK);
    localparam int unsigned C_PCW       = (C_PACK_LOG2 > 0) ? C_PACK_LOG2 : 1;
    localparam int unsigned C_WAW       = C_RAM_ADDR_WIDTH - C_PACK_LOG2;
    localparam int unsigned C_BEAT_LOG2 = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam int unsigned C_BW        = $clog2(C_MAX_BURST) + 1;
    localparam int unsigned C_DEPTH     = 2 ** (C_WAW + 1);

    typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

    state_e                                   r_state;
    logic                                     r_start_q;
    logic                                     r_busy;
    logic                                     r_done;
    logic                                     r_arvalid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]            r_araddr;
    logic [C_M_AXI_LEN_WIDTH-1:0]             r_arlen;
    logic                                     r_rready;
    logic [C_RAM_ADDR_WIDTH-1:0]              r_remain;
    logic [C_BW-1:0]                          r_burst_len;
    logic [C_BW-1:0]                          r_burst_left;
    logic [C_PACK-1:0][C_M_AXI_DATA_WIDTH-1:0] r_pack;
    logic [C_PCW-1:0]                         r_pack_cnt;
    logic [C_WAW-1:0]                         r_word_cnt;
    logic                                     r_wbank;
    logic                                     r_wr_en;
    logic [C_WAW:0]                           r_wr_addr;
    logic [C_LBIAS_WIDTH-1:0]                 r_wr_data;
    logic [C_LBIAS_WIDTH-1:0]                 r_brdata;
    logic [C_LBIAS_WIDTH-1:0]                 r_mem [C_DEPTH];

    logic                                     w_start_edge;
    logic                                     w_beat;
    logic                                     w_last_load;
    logic                                     w_last_burst;
    logic                                     w_pack_wrap;
    logic [C_PACK-1:0][C_M_AXI_DATA_WIDTH-1:0] w_pack_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]            w_next_addr;
    logic [C_RAM_ADDR_WIDTH-1:0]              w_remain_dec;
    logic [C_BW-1:0]                          w_first_burst;
    logic [C_BW-1:0]                          w_next_burst;
    logic [C_BW-1:0]                          w_first_len;
    logic [C_BW-1:0]                          w_next_len;

    // Beats for the next burst: min(remaining, max burst, beats left in the 4 KB page).
    function automatic logic [C_BW-1:0] f_burst(input logic [11:0]                 off,
                                                input logic [C_RAM_ADDR_WIDTH-1:0] remain);
        logic [12:0] page_bytes;
        logic [31:0] page_beats;
        logic [31:0] rem32;
        logic [31:0] beats;
        page_bytes = 13'h1000 - {1'b0, off};
        page_beats = 32'(page_bytes) >> C_BEAT_LOG2;
        rem32      = 32'(remain);
        beats      = 32'(C_MAX_BURST);
        if (page_beats < beats) beats = page_beats;
        if (rem32 < beats) beats = rem32;
        return C_BW'(beats);
    endfunction

    assign w_start_edge  = I_ap_start & ~r_start_q;
    assign w_beat        = (r_state == StR) & r_rready & m_axi.I_maxi_rvalid;
    assign w_last_load   = (r_remain == C_RAM_ADDR_WIDTH'(1));
    assign w_last_burst  = (r_burst_left == C_BW'(1));
    assign w_pack_wrap   = (r_pack_cnt == C_PCW'(C_PACK - 1));
    assign w_remain_dec  = r_remain - C_RAM_ADDR_WIDTH'(1);
    assign w_next_addr   = r_araddr + (C_M_AXI_ADDR_WIDTH'(r_burst_len) << C_BEAT_LOG2);
    assign w_first_burst = f_burst(I_base_addr[11:0], I_len);
    assign w_next_burst  = f_burst(w_next_addr[11:0], w_remain_dec);
    assign w_first_len   = w_first_burst - C_BW'(1);
    assign w_next_len    = w_next_burst - C_BW'(1);

    // Lanes above the current beat stay zero because r_pack is cleared after every word.
    always_comb begin
        w_pack_next             = r_pack;
        w_pack_next[r_pack_cnt] = m_axi.I_maxi_rdata;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state      <= StIdle;
            r_start_q    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_rready     <= 1'b0;
            r_remain     <= '0;
            r_burst_len  <= '0;
            r_burst_left <= '0;
            r_pack       <= '0;
            r_pack_cnt   <= '0;
            r_word_cnt   <= '0;
            r_wbank      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_start_q <= I_ap_start;
            r_wr_en   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start_edge) begin
                        r_busy     <= 1'b1;
                        r_wbank    <= I_wbank;
                        r_word_cnt <= '0;
                        r_pack_cnt <= '0;
                        r_pack     <= '0;
                        r_remain   <= I_len;
                        if (I_len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= StAr;
                            r_arvalid   <= 1'b1;
                            r_araddr    <= I_base_addr;
                            r_arlen     <= C_M_AXI_LEN_WIDTH'(w_first_len);
                            r_burst_len <= w_first_burst;
                        end
                    end
                end
                StAr: begin
                    if (m_axi.I_maxi_arready) begin
                        r_arvalid    <= 1'b0;
                        r_rready     <= 1'b1;
                        r_burst_left <= r_burst_len;
                        r_state      <= StR;
                    end
                end
                StR: begin
                    if (w_beat) begin
                        r_remain     <= w_remain_dec;
                        r_burst_left <= r_burst_left - C_BW'(1);
                        r_pack       <= w_pack_next;
                        r_pack_cnt   <= r_pack_cnt + C_PCW'(1);
                        if (w_pack_wrap || w_last_load) begin
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= w_pack_next;
                            r_wr_addr  <= {r_wbank, r_word_cnt};
                            r_word_cnt <= r_word_cnt + C_WAW'(1);
                            r_pack     <= '0;
                            r_pack_cnt <= '0;
                        end
                        if (w_last_load) begin
                            r_rready <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end else if (w_last_burst) begin
                            r_rready    <= 1'b0;
                            r_arvalid   <= 1'b1;
                            r_araddr    <= w_next_addr;
                            r_arlen     <= C_M_AXI_LEN_WIDTH'(w_next_len);
                            r_burst_len <= w_next_burst;
                            r_state     <= StAr;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // RAM is not reset; non-blocking read of the old entry gives read-first behaviour.
    always_ff @(posedge I_clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
        r_brdata <= r_mem[{I_rbank, I_braddr}];
    end

    assign O_ap_done             = r_done;
    assign O_busy                = r_busy;
    assign O_brdata              = r_brdata;
    assign m_axi.O_maxi_arvalid  = r_arvalid;
    assign m_axi.O_maxi_araddr   = r_araddr;
    assign m_axi.O_maxi_arlen    = r_arlen;
    assign m_axi.O_stable_rready = r_rready;

endmodule
